pixel_scanout: RTL and testbench



---
 rtl/scanout_pkg.sv | 38 +++
 rtl/pixel_scanout_pix_delay.sv | 26 ++
 rtl/pixel_scanout.sv | 106 ++++++++++
 tb/tb_pixel_scanout.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scanout_pkg.sv
// scanout_pkg: shared types and constants for pixel_scanout (test bars used when SCANOUT_TESTPAT_EN is defined)
package scanout_pkg;

    localparam int DEF_CORDW = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic {WAIT_SOF, ACTIVE} scan_state_t;

    localparam rgb444_t BAR_WHITE   = 12'hFFF;
    localparam rgb444_t BAR_YELLOW  = 12'hFF0;
    localparam rgb444_t BAR_CYAN    = 12'h0FF;
    localparam rgb444_t BAR_GREEN   = 12'h0F0;
    localparam rgb444_t BAR_MAGENTA = 12'hF0F;
    localparam rgb444_t BAR_RED     = 12'hF00;
    localparam rgb444_t BAR_BLUE    = 12'h00F;
    localparam rgb444_t BAR_BLACK   = 12'h000;

    // index 0 is the leftmost bar
    localparam rgb444_t [7:0] TEST_BARS = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                           BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};

    // nibble replication so full-scale 0xF maps to full-scale 0xFF
    function automatic rgb888_t expand444(input rgb444_t c);
        return '{r: {c.r, c.r}, g: {c.g, c.g}, b: {c.b, c.b}};
    endfunction

endpackage

// File: rtl/pixel_scanout_pix_delay.sv
// pix_delay: WIDTH x DEPTH shift register with synchronous active-low clear
module pix_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    // shift one tap per pixel clock; reset empties every tap
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/pixel_scanout.sv
// pixel_scanout: raster-to-framebuffer read, colour alignment and expansion; SCANOUT_TESTPAT_EN adds colour bars
module pixel_scanout
    import scanout_pkg::*;
#(
    parameter int CORDW       = DEF_CORDW,
    parameter int READ_LAT    = 1,
    parameter int SCALE_SHIFT = 0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    input  logic [11:0]      rd_color,
    input  logic             test_mode,
    output logic [CORDW-1:0] rd_x,
    output logic [CORDW-1:0] rd_y,
    output logic [CORDW-1:0] sdl_sx,
    output logic [CORDW-1:0] sdl_sy,
    output logic             sdl_de,
    output logic [7:0]       sdl_r,
    output logic [7:0]       sdl_g,
    output logic [7:0]       sdl_b,
    output logic [15:0]      frame_count
);

    // read register + READ_LAT memory + output register; the delay line covers all but the output register
    localparam int L = READ_LAT + 2;

    scan_state_t      state, state_next;
    logic             sof, armed;
    logic [CORDW-1:0] d_sx, d_sy;
    logic             d_de;
    rgb444_t          src;
    rgb888_t          pix;

    assign sof = de && sx == '0 && sy == '0;

    // the SOF pixel itself is already displayed, so armed includes it
    always_comb begin
        state_next = sof ? ACTIVE : state;
        armed      = state == ACTIVE || sof;
    end

    // state register
    always_ff @(posedge clk_pix) begin
        state <= !rst_pix_n ? WAIT_SOF : state_next;
    end

    // read coordinates follow the raster during active video and hold through blanking
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            rd_x <= '0;
            rd_y <= '0;
        end else if (de) begin
            rd_x <= sx >> SCALE_SHIFT;
            rd_y <= sy >> SCALE_SHIFT;
        end
    end

    // frame counter, wraps at 16 bits
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) frame_count <= '0;
        else if (sof)   frame_count <= frame_count + 16'd1;
    end

    pix_delay #(
        .WIDTH(2 * CORDW + 1),
        .DEPTH(L - 1)
    ) u_dly (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .d        ({sx, sy, de && armed}),
        .q        ({d_sx, d_sy, d_de})
    );

`ifdef SCANOUT_TESTPAT_EN
    assign src = test_mode ? TEST_BARS[d_sx[CORDW-1 -: 3]] : rgb444_t'(rd_color);
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign src = rd_color;
`endif

    assign pix = expand444(src);

    // output register: aligned coordinates and colour, black outside the armed active area
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            sdl_sx <= '0;
            sdl_sy <= '0;
            sdl_de <= 1'b0;
            sdl_r  <= '0;
            sdl_g  <= '0;
            sdl_b  <= '0;
        end else begin
            sdl_sx <= d_sx;
            sdl_sy <= d_sy;
            sdl_de <= d_de;
            sdl_r  <= d_de ? pix.r : 8'd0;
            sdl_g  <= d_de ? pix.g : 8'd0;
            sdl_b  <= d_de ? pix.b : 8'd0;
        end
    end

endmodule

// File: tb/tb_pixel_scanout.sv
// tb_pixel_scanout: randomized raster stimulus against a frame-level reference model of pixel_scanout
module tb_pixel_scanout;

    localparam int CORDW = 10;
    localparam int RL    = 2;
    localparam int SS    = 1;
    localparam int L     = RL + 2;

    logic             clk_pix = 1'b0;
    logic             rst_pix_n = 1'b0;
    logic [CORDW-1:0] sx = '0, sy = '0;
    logic             de = 1'b0, test_mode = 1'b0;
    logic [11:0]      rd_color;
    logic [CORDW-1:0] rd_x, rd_y, sdl_sx, sdl_sy;
    logic             sdl_de;
    logic [7:0]       sdl_r, sdl_g, sdl_b;
    logic [15:0]      frame_count;

    pixel_scanout #(
        .CORDW(CORDW),
        .READ_LAT(RL),
        .SCALE_SHIFT(SS)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_pix_n  (rst_pix_n),
        .sx         (sx),
        .sy         (sy),
        .de         (de),
        .rd_color   (rd_color),
        .test_mode  (test_mode),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .sdl_sx     (sdl_sx),
        .sdl_sy     (sdl_sy),
        .sdl_de     (sdl_de),
        .sdl_r      (sdl_r),
        .sdl_g      (sdl_g),
        .sdl_b      (sdl_b),
        .frame_count(frame_count)
    );

    always #5 clk_pix = ~clk_pix;

    // frame buffer: 64x64 image, RL registered stages from rd_x/rd_y to rd_color
    logic [11:0] mem [64][64];
    logic [11:0] rq [RL];

    always @(posedge clk_pix) begin
        rq[0] <= mem[rd_y[5:0]][rd_x[5:0]];
        for (int i = 1; i < RL; i++) rq[i] <= rq[i-1];
    end

    assign rd_color = rq[RL-1];

    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic [11:0] c;
    } exp_t;

    exp_t        hist[$];
    logic        m_armed;
    logic [15:0] m_cnt;
    logic [9:0]  m_rdx, m_rdy;
    int          n_cmp = 0, n_bad = 0;
    int          px = 0, py = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] x2(input logic [3:0] n);
        return {n, n};
    endfunction

    // one pixel clock: drive inputs, advance the model, compare every output after the edge
    task automatic tick(input logic r, input logic [9:0] x, input logic [9:0] y, input logic d);
        exp_t        e, o;
        logic        sof;
        logic [9:0]  xs, ys;
        logic [11:0] c;
        rst_pix_n = !r;
        sx = x;
        sy = y;
        de = d;
        sof = d && x == 0 && y == 0;
        xs = x >> SS;
        ys = y >> SS;
        if (r) begin
            e = '{x: 0, y: 0, de: 0, c: 0};
            hist.delete();
            repeat (L) hist.push_back(e);
            m_armed = 0;
            m_cnt = 0;
            m_rdx = 0;
            m_rdy = 0;
        end else begin
            e = '{x: x, y: y, de: d && (m_armed || sof), c: mem[ys[5:0]][xs[5:0]]};
            hist.push_back(e);
            hist.delete(0);
            m_armed = m_armed || sof;
            if (sof) m_cnt = m_cnt + 16'd1;
            if (d) begin
                m_rdx = xs;
                m_rdy = ys;
            end
        end
        @(posedge clk_pix);
        #1;
        o = hist[0];
        c = o.c;
`ifdef SCANOUT_TESTPAT_EN
        if (test_mode) c = BARS[o.x[9:7]];
`endif
        if (!o.de) c = 12'h000;
        check("rd_x", rd_x, m_rdx);
        check("rd_y", rd_y, m_rdy);
        check("frame_count", frame_count, m_cnt);
        check("sdl_sx", sdl_sx, o.x);
        check("sdl_sy", sdl_sy, o.y);
        check("sdl_de", sdl_de, o.de);
        check("sdl_r", sdl_r, x2(c[11:8]));
        check("sdl_g", sdl_g, x2(c[7:4]));
        check("sdl_b", sdl_b, x2(c[3:0]));
    endtask

    // free-running raster with optional random de dropouts
    task automatic raster(input int n, input int wt, input int ht, input int wa, input int ha, input bit drop);
        logic d;
        for (int i = 0; i < n; i++) begin
            d = px < wa && py < ha && !(drop && $urandom_range(7) == 0);
            tick(0, 10'(px), 10'(py), d);
            px++;
            if (px == wt) begin
                px = 0;
                py = (py + 1) % ht;
            end
        end
    endtask

    initial begin
        logic [11:0] c;
        foreach (mem[i, j]) mem[i][j] = 12'($urandom);
        for (int i = 0; i < RL; i++) rq[i] = 12'h000;

        repeat (3) tick(1, 10'($urandom), 10'($urandom), 1'b1);
        check("reset_cnt", frame_count, 16'h0000);
        check("reset_de", sdl_de, 1'b0);

        px = 100;
        py = 50;
        raster(1100, 120, 60, 104, 56, 1'b0);
        check("pre_sof_cnt", frame_count, 16'h0000);
        check("pre_sof_de", sdl_de, 1'b0);
        raster(1, 120, 60, 104, 56, 1'b0);
        check("first_sof_cnt", frame_count, 16'h0001);
        raster(L - 1, 120, 60, 104, 56, 1'b0);
        check("first_sof_de", sdl_de, 1'b1);
        check("first_sof_sx", sdl_sx, 10'd0);
        raster(2000, 120, 60, 104, 56, 1'b1);

        mem[1][3] = 12'hFFF;
        for (int i = 0; i < 8; i++) begin
            tick(0, 10'(i), 10'd3, 1'b1);
            check("sweep_rd_x", rd_x, 10'(i / 2));
            check("sweep_rd_y", rd_y, 10'd1);
        end
        repeat (L + 2) tick(0, 10'd200, 10'd3, 1'b0);
        check("blank_rd_x", rd_x, 10'd3);
        check("blank_rd_y", rd_y, 10'd1);
        check("blank_rd_color", rd_color, 12'hFFF);
        check("blank_r", sdl_r, 8'h00);

        test_mode = 1'b0;
        mem[10][5] = 12'hA5C;
        tick(0, 10'd10, 10'd20, 1'b1);
        repeat (L - 1) tick(0, 10'd300, 10'd20, 1'b0);
        check("a5c_sx", sdl_sx, 10'd10);
        check("a5c_sy", sdl_sy, 10'd20);
        check("a5c_de", sdl_de, 1'b1);
        check("a5c_r", sdl_r, 8'hAA);
        check("a5c_g", sdl_g, 8'h55);
        check("a5c_b", sdl_b, 8'hCC);

        px = 0;
        py = 0;
        for (int f = 0; f < 5; f++) begin
            test_mode = 1'($urandom);
            raster(800, 40, 20, 32, 16, 1'b1);
        end
        test_mode = 1'b0;

        px = 10;
        py = 5;
        tick(1, 10'd10, 10'd5, 1'b1);
        check("pulse_de", sdl_de, 1'b0);
        check("pulse_r", sdl_r, 8'h00);
        check("pulse_cnt", frame_count, 16'h0000);
        check("pulse_rd_x", rd_x, 10'd0);
        px = 11;
        raster(900, 40, 20, 32, 16, 1'b0);

        test_mode = 1'b1;
        tick(0, 10'd0, 10'd5, 1'b1);
        repeat (L - 1) tick(0, 10'd900, 10'd5, 1'b0);
`ifdef SCANOUT_TESTPAT_EN
        c = 12'hFFF;
`else
        c = mem[2][0];
`endif
        check("bar0_r", sdl_r, x2(c[11:8]));
        check("bar0_g", sdl_g, x2(c[7:4]));
        check("bar0_b", sdl_b, x2(c[3:0]));
        tick(0, 10'd640, 10'd5, 1'b1);
        repeat (L - 1) tick(0, 10'd900, 10'd5, 1'b0);
`ifdef SCANOUT_TESTPAT_EN
        c = 12'hF00;
`else
        c = mem[2][0];
`endif
        check("bar5_r", sdl_r, x2(c[11:8]));
        check("bar5_g", sdl_g, x2(c[7:4]));
        check("bar5_b", sdl_b, x2(c[3:0]));
        test_mode = 1'b0;

        tick(1, 10'd0, 10'd0, 1'b0);
        repeat (65534) tick(0, 10'd0, 10'd0, 1'b1);
        check("wrap_fffe", frame_count, 16'hFFFE);
        tick(0, 10'd0, 10'd0, 1'b1);
        check("wrap_ffff", frame_count, 16'hFFFF);
        tick(0, 10'd0, 10'd0, 1'b1);
        check("wrap_0000", frame_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
